// File: rtl/audio_meter_pkg.sv
// Shared widths, saturation constants and magnitude helper for the audio level meter.
package audio_meter_pkg;

  localparam int unsigned DEF_SAMPLE_W = 24;
  localparam int unsigned DEF_LEVEL_W  = 8;
  localparam int unsigned DEF_MAG_W    = DEF_SAMPLE_W - 1;

  localparam logic signed [DEF_SAMPLE_W-1:0] SAT_POS = {1'b0, {(DEF_SAMPLE_W-1){1'b1}}};
  localparam logic signed [DEF_SAMPLE_W-1:0] SAT_NEG = {1'b1, {(DEF_SAMPLE_W-1){1'b0}}};

  typedef logic [DEF_LEVEL_W-1:0] level_t;
  typedef logic [DEF_MAG_W-1:0]   mag_t;

  // Magnitude at SAMPLE_W-1 bits; the most-negative code saturates to full scale.
  function automatic mag_t abs_sat(input logic signed [DEF_SAMPLE_W-1:0] s);
    logic [DEF_SAMPLE_W-1:0] neg;
    neg = DEF_SAMPLE_W'(-s);
    if (s == SAT_NEG) return SAT_POS[DEF_MAG_W-1:0];
    return s[DEF_SAMPLE_W-1] ? neg[DEF_MAG_W-1:0] : s[DEF_MAG_W-1:0];
  endfunction

endpackage

// File: rtl/audio_peak_channel.sv
// One audio channel: magnitude/saturation capture, windowed running max,
// and the level, peak-hold/decay and clip-hold output registers.
module audio_peak_channel
  import audio_meter_pkg::*;
#(
  parameter int unsigned SAMPLE_W     = DEF_SAMPLE_W,
  parameter int unsigned LEVEL_W      = DEF_LEVEL_W,
  parameter int unsigned HOLD_WINDOWS = 8,
  parameter int unsigned DECAY_STEP   = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic                       last,
  input  logic signed [SAMPLE_W-1:0] sample,
  output logic [LEVEL_W-1:0]         level,
  output logic [LEVEL_W-1:0]         peak,
  output logic                       clip
);

  localparam int unsigned MAG_W  = SAMPLE_W - 1;
  localparam int unsigned HOLD_W = $clog2(HOLD_WINDOWS + 1);

  logic               v1_q;
  logic               last1_q;
  logic               sat_q;
  logic [MAG_W-1:0]   abs_q;
  logic [MAG_W-1:0]   run_max_q;
  logic               run_clip_q;
  logic [HOLD_W-1:0]  hold_q;
  logic [HOLD_W-1:0]  clip_cnt_q;

  logic [MAG_W-1:0]   win_max_c;
  logic               win_clip_c;
  logic [LEVEL_W-1:0] level_new_c;

  // Stage 1: magnitude and full-scale detection of the accepted sample.
  always_ff @(posedge clock) begin
    if (reset) begin
      v1_q    <= 1'b0;
      last1_q <= 1'b0;
      sat_q   <= 1'b0;
      abs_q   <= '0;
    end else begin
      v1_q <= in_valid;
      if (in_valid) begin
        abs_q   <= abs_sat(sample);
        sat_q   <= (sample == SAT_POS) || (sample == SAT_NEG);
        last1_q <= last;
      end
    end
  end

  // Window result including the sample currently in stage 1.
  always_comb begin
    win_max_c   = (abs_q > run_max_q) ? abs_q : run_max_q;
    win_clip_c  = run_clip_q | sat_q;
    level_new_c = win_max_c[MAG_W-1 -: LEVEL_W];
  end

  // Stage 2: accumulate, and on the closing sample publish level/peak/clip.
  always_ff @(posedge clock) begin
    if (reset) begin
      run_max_q  <= '0;
      run_clip_q <= 1'b0;
      level      <= '0;
      peak       <= '0;
      clip       <= 1'b0;
      hold_q     <= '0;
      clip_cnt_q <= '0;
    end else if (v1_q) begin
      if (last1_q) begin
        run_max_q  <= '0;
        run_clip_q <= 1'b0;
        level      <= level_new_c;

        if (level_new_c >= peak) begin
          peak   <= level_new_c;
          hold_q <= HOLD_W'(HOLD_WINDOWS);
        end else if (hold_q != '0) begin
          hold_q <= hold_q - HOLD_W'(1);
        end else if (peak > LEVEL_W'(DECAY_STEP)) begin
          peak <= peak - LEVEL_W'(DECAY_STEP);
        end else begin
          peak <= '0;
        end

        if (win_clip_c) begin
          clip       <= 1'b1;
          clip_cnt_q <= HOLD_W'(HOLD_WINDOWS);
        end else if (clip_cnt_q != '0) begin
          clip_cnt_q <= clip_cnt_q - HOLD_W'(1);
        end else begin
          clip <= 1'b0;
        end
      end else begin
        run_max_q  <= win_max_c;
        run_clip_q <= win_clip_c;
      end
    end
  end

endmodule

// File: rtl/audio_peak_meter.sv
// Stereo windowed level / peak-hold / clip meter; owns the shared window
// counter and the update strobe, channels do the per-sample work.
module audio_peak_meter
  import audio_meter_pkg::*;
#(
  parameter int unsigned SAMPLE_W     = DEF_SAMPLE_W,
  parameter int unsigned LEVEL_W      = DEF_LEVEL_W,
  parameter int unsigned WINDOW       = 1024,
  parameter int unsigned HOLD_WINDOWS = 8,
  parameter int unsigned DECAY_STEP   = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic signed [SAMPLE_W-1:0] in_l,
  input  logic signed [SAMPLE_W-1:0] in_r,
  output logic [LEVEL_W-1:0]         level_l,
  output logic [LEVEL_W-1:0]         level_r,
  output logic [LEVEL_W-1:0]         peak_l,
  output logic [LEVEL_W-1:0]         peak_r,
  output logic                       clip_l,
  output logic                       clip_r,
  output logic                       out_valid
);

  localparam int unsigned CNT_W = $clog2(WINDOW);

  logic [CNT_W-1:0] win_cnt_q;
  logic             v1_q;
  logic             last1_q;
  logic             last_c;

  assign last_c = (win_cnt_q == CNT_W'(WINDOW - 1));

  // Window counter wraps naturally since WINDOW is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      win_cnt_q <= '0;
      v1_q      <= 1'b0;
      last1_q   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      v1_q      <= in_valid;
      out_valid <= v1_q & last1_q;
      if (in_valid) begin
        win_cnt_q <= win_cnt_q + CNT_W'(1);
        last1_q   <= last_c;
      end
    end
  end

  audio_peak_channel #(
    .SAMPLE_W    (SAMPLE_W),
    .LEVEL_W     (LEVEL_W),
    .HOLD_WINDOWS(HOLD_WINDOWS),
    .DECAY_STEP  (DECAY_STEP)
  ) u_left (
    .clock   (clock),
    .reset   (reset),
    .in_valid(in_valid),
    .last    (last_c),
    .sample  (in_l),
    .level   (level_l),
    .peak    (peak_l),
    .clip    (clip_l)
  );

  audio_peak_channel #(
    .SAMPLE_W    (SAMPLE_W),
    .LEVEL_W     (LEVEL_W),
    .HOLD_WINDOWS(HOLD_WINDOWS),
    .DECAY_STEP  (DECAY_STEP)
  ) u_right (
    .clock   (clock),
    .reset   (reset),
    .in_valid(in_valid),
    .last    (last_c),
    .sample  (in_r),
    .level   (level_r),
    .peak    (peak_r),
    .clip    (clip_r)
  );

endmodule
